turn_scheduler: RTL and testbench
=================================

# turn_scheduler

Turn scheduler for the two-player game datapath. It sequences the shared cycle counter, which produces one tick pulse per elapsed period. It enables that counter only while a turn is running, counts down the per-turn time budget from its ticks, and alternates the turn between player 0 and player 1 on a completed move or a timeout. Its outputs feed the game FSM and the display logic.

## Interface
- TURN_SECONDS, default 15: ticks allowed per turn; legal range 2..31.
- SW, default $clog2(TURN_SECONDS+1): width of secs_left; derived, never overridden.
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level; begins a game when sampled in IDLE, ignored elsewhere.
- move_done  input  1  one-cycle pulse: current player finished a move.
- pause  input  1  level; freezes the running turn while high.
- game_over  input  1  one-cycle pulse: ends the game from any non-IDLE state.
- cyc_tick  input  1  one-cycle pulse from the cycle counter at each elapsed period.
- cyc_en  output  1  enable to the cycle counter.
- active  output  1  high in any state except IDLE.
- turn  output  1  current player (0 or 1).
- secs_left  output  SW  remaining ticks of the current turn.
- swap  output  1  one-cycle pulse on every turn change.
- timeout  output  1  one-cycle pulse, coincident with swap, when the change was caused by expiry.
- turn_count  output  8  number of completed turns; wraps 255 -> 0.

## Operation
- All outputs are registered or decoded only from state. Reset clears every output to 0 and sets state to IDLE.
- IDLE: cyc_en=0, active=0. Sampling start=1 loads turn=0, secs_left=TURN_SECONDS and turn_count=0, then moves to RUN.
- RUN: cyc_en=1, active=1. Input priority per cycle is game_over, then move_done, then cyc_tick, then pause.
  - game_over -> IDLE. turn, turn_count and secs_left hold their values for display.
  - move_done -> SWAP with cause "move".
  - cyc_tick with secs_left>1 -> secs_left decrements by 1; state stays RUN.
  - cyc_tick with secs_left==1 -> SWAP with cause "timeout".
  - pause=1 with none of the above -> HOLD; secs_left unchanged.
- On entry to SWAP, registered in the same edge:
  - turn toggles;
  - secs_left reloads to TURN_SECONDS;
  - turn_count increments, modulo 256;
  - swap=1;
  - timeout=1 only if the cause was "timeout".
- SWAP: cyc_en=0, lasts exactly one cycle. game_over -> IDLE; otherwise -> RUN. pause, move_done and cyc_tick are ignored during SWAP.
- HOLD: cyc_en=0. move_done and cyc_tick are ignored. game_over -> IDLE. pause=0 -> RUN with secs_left unchanged.
- start is ignored outside IDLE. game_over in IDLE is ignored.
- secs_left never wraps below 1 while in RUN. It holds the value 0 only after reset, before the first start.
- rst=1 mid-operation returns to IDLE with all outputs 0 on the next edge, regardless of other inputs.

## Timing
- start sampled at edge k: at k+1, state=RUN, cyc_en=1, active=1, secs_left=TURN_SECONDS.
- Event (move_done, or the final cyc_tick) sampled at edge k:
  - at k+1: swap=1, timeout per cause, new turn and reloaded secs_left visible, cyc_en=0;
  - at k+2: RUN, cyc_en=1, swap=0, timeout=0.
- Non-final cyc_tick at edge k: secs_left decremented at k+1.
- pause rising, sampled at edge k: cyc_en=0 at k+1. pause falling, sampled at edge j: cyc_en=1 at j+1.
- move_done and the final cyc_tick in the same cycle: move wins; swap=1, timeout=0.
- game_over together with any other event: IDLE at next edge; no swap pulse.
- swap and timeout are never high for more than one consecutive cycle.

## Test plan
All scenarios use TURN_SECONDS=3.
1. Reset: hold rst 2 cycles with start=1 -> all outputs 0, state IDLE. Release rst, start=1 one cycle -> next cycle cyc_en=1, active=1, turn=0, secs_left=3, turn_count=0.
2. Timeout: after start, three cyc_tick pulses spaced 4 cycles apart -> secs_left goes 3,2,1. Third tick -> one cycle with swap=1, timeout=1, turn=1, secs_left=3, turn_count=1, cyc_en=0; next cycle cyc_en=1.
3. Move: after one tick (secs_left=2), pulse move_done -> swap=1, timeout=0, turn=1, secs_left=3, turn_count=1.
4. Pause: with secs_left=2, pause=1 for 10 cycles while issuing cyc_tick and move_done -> cyc_en=0, secs_left stays 2, no swap. Drop pause -> cyc_en=1 next cycle; next tick gives secs_left=1.
5. Collisions:
   - move_done and final cyc_tick in the same cycle -> swap=1, timeout=0.
   - game_over with move_done in RUN -> IDLE next cycle, active=0, cyc_en=0, no swap; turn and turn_count held.
   - start while in RUN -> no effect.
6. Wrap and reset mid-game: 256 move_done pulses, one per RUN cycle -> turn_count returns to 0 and turn=0. Then rst asserted during SWAP -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/turn_scheduler_if.sv
// Control/status bundle between the turn scheduler and the game FSM, display and cycle counter.
// master drives the game events; slave is the scheduler.
interface turn_scheduler_if #(
  parameter int TURN_SECONDS = 15
);
  localparam int SW = $clog2(TURN_SECONDS + 1);

  logic          start;
  logic          move_done;
  logic          pause;
  logic          game_over;
  logic          cyc_tick;

  logic          cyc_en;
  logic          active;
  logic          turn;
  logic [SW-1:0] secs_left;
  logic          swap;
  logic          timeout;
  logic [7:0]    turn_count;

  modport master (
    output start, move_done, pause, game_over, cyc_tick,
    input  cyc_en, active, turn, secs_left, swap, timeout, turn_count
  );

  modport slave (
    input  start, move_done, pause, game_over, cyc_tick,
    output cyc_en, active, turn, secs_left, swap, timeout, turn_count
  );
endinterface

// File: rtl/turn_scheduler.sv
// Two-player turn scheduler: gates the cycle counter, counts down the turn budget, alternates turns.
// One-edge response to every event; no backpressure, events outside RUN (except game_over) are dropped.
module turn_scheduler #(
  parameter int TURN_SECONDS = 15
) (
  input  logic             clk,
  input  logic             rst,
  turn_scheduler_if.slave  bus
);
  localparam int SW = $clog2(TURN_SECONDS + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] SWAP = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam logic [SW-1:0] RELOAD = SW'(TURN_SECONDS);
  localparam logic [SW-1:0] ONE    = SW'(1);

  logic [1:0]    state_q, state_d;
  logic          turn_q;
  logic [SW-1:0] secs_q;
  logic [7:0]    count_q;
  logic          swap_q;
  logic          timeout_q;

  logic          load_game;
  logic          enter_swap;
  logic          by_timeout;
  logic          dec_secs;

  always_comb begin
    state_d    = state_q;
    load_game  = 1'b0;
    enter_swap = 1'b0;
    by_timeout = 1'b0;
    dec_secs   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load_game = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        // game_over > move_done > cyc_tick > pause
        if (bus.game_over) begin
          state_d = IDLE;
        end else if (bus.move_done) begin
          enter_swap = 1'b1;
          state_d    = SWAP;
        end else if (bus.cyc_tick) begin
          if (secs_q > ONE) begin
            dec_secs = 1'b1;
          end else begin
            enter_swap = 1'b1;
            by_timeout = 1'b1;
            state_d    = SWAP;
          end
        end else if (bus.pause) begin
          state_d = HOLD;
        end
      end
      SWAP: begin
        state_d = bus.game_over ? IDLE : RUN;
      end
      HOLD: begin
        if (bus.game_over) begin
          state_d = IDLE;
        end else if (!bus.pause) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      turn_q    <= 1'b0;
      secs_q    <= '0;
      count_q   <= '0;
      swap_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      swap_q    <= enter_swap;
      timeout_q <= by_timeout;
      if (load_game) begin
        turn_q  <= 1'b0;
        secs_q  <= RELOAD;
        count_q <= '0;
      end else if (enter_swap) begin
        turn_q  <= ~turn_q;
        secs_q  <= RELOAD;
        count_q <= count_q + 8'd1;
      end else if (dec_secs) begin
        secs_q  <= secs_q - ONE;
      end
    end
  end

  // The counter only runs while a turn is actively being timed.
  assign bus.cyc_en     = (state_q == RUN);
  assign bus.active     = (state_q != IDLE);
  assign bus.turn       = turn_q;
  assign bus.secs_left  = secs_q;
  assign bus.swap       = swap_q;
  assign bus.timeout    = timeout_q;
  assign bus.turn_count = count_q;

  a_swap_single : assert property (@(posedge clk) disable iff (rst) swap_q |=> !swap_q);
  a_timeout_with_swap : assert property (@(posedge clk) disable iff (rst) timeout_q |-> swap_q);
  a_secs_nonzero_run : assert property (@(posedge clk) disable iff (rst)
                                        (state_q == RUN) |-> (secs_q != '0));

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler with a 3-tick turn budget.
module tb_turn_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  turn_scheduler_if #(.TURN_SECONDS(3)) bus ();

  turn_scheduler #(.TURN_SECONDS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic en, input logic act, input logic trn,
                         input logic [1:0] secs, input logic sw, input logic to,
                         input logic [7:0] cnt);
    chk({tag, ".cyc_en"},     32'(bus.cyc_en),     32'(en));
    chk({tag, ".active"},     32'(bus.active),     32'(act));
    chk({tag, ".turn"},       32'(bus.turn),       32'(trn));
    chk({tag, ".secs_left"},  32'(bus.secs_left),  32'(secs));
    chk({tag, ".swap"},       32'(bus.swap),       32'(sw));
    chk({tag, ".timeout"},    32'(bus.timeout),    32'(to));
    chk({tag, ".turn_count"}, 32'(bus.turn_count), 32'(cnt));
  endtask

  task automatic tick();
    bus.cyc_tick = 1'b1;
    cyc(1);
    bus.cyc_tick = 1'b0;
  endtask

  task automatic move();
    bus.move_done = 1'b1;
    cyc(1);
    bus.move_done = 1'b0;
  endtask

  initial begin
    bus.start     = 1'b1;
    bus.move_done = 1'b0;
    bus.pause     = 1'b0;
    bus.game_over = 1'b0;
    bus.cyc_tick  = 1'b0;

    // 1. reset holds everything at zero even with start high
    cyc(2);
    chk_all("reset", 0, 0, 0, 2'd0, 0, 0, 8'd0);
    rst = 1'b0;
    cyc(1);
    bus.start = 1'b0;
    chk_all("start", 1, 1, 0, 2'd3, 0, 0, 8'd0);

    // 2. timeout after three ticks
    tick();
    chk("to.tick1", 32'(bus.secs_left), 32'd2);
    cyc(3);
    tick();
    chk("to.tick2", 32'(bus.secs_left), 32'd1);
    cyc(3);
    tick();
    chk_all("to.swap", 0, 1, 1, 2'd3, 1, 1, 8'd1);
    cyc(1);
    chk_all("to.run", 1, 1, 1, 2'd3, 0, 0, 8'd1);

    // 3. completed move
    tick();
    chk("mv.tick", 32'(bus.secs_left), 32'd2);
    move();
    chk_all("mv.swap", 0, 1, 0, 2'd3, 1, 0, 8'd2);
    cyc(1);
    chk_all("mv.run", 1, 1, 0, 2'd3, 0, 0, 8'd2);

    // 4. pause freezes the turn and ignores events
    tick();
    chk("ps.tick", 32'(bus.secs_left), 32'd2);
    bus.pause = 1'b1;
    cyc(1);
    chk_all("ps.enter", 0, 1, 0, 2'd2, 0, 0, 8'd2);
    for (int i = 0; i < 10; i++) begin
      bus.cyc_tick  = i[0];
      bus.move_done = ~i[0];
      cyc(1);
      chk("ps.hold.swap", 32'(bus.swap), 32'd0);
      chk("ps.hold.secs", 32'(bus.secs_left), 32'd2);
      chk("ps.hold.en", 32'(bus.cyc_en), 32'd0);
    end
    bus.cyc_tick  = 1'b0;
    bus.move_done = 1'b0;
    bus.pause     = 1'b0;
    cyc(1);
    chk_all("ps.resume", 1, 1, 0, 2'd2, 0, 0, 8'd2);
    tick();
    chk("ps.tick2", 32'(bus.secs_left), 32'd1);

    // 5a. move and final tick together: move wins
    bus.move_done = 1'b1;
    bus.cyc_tick  = 1'b1;
    cyc(1);
    bus.move_done = 1'b0;
    bus.cyc_tick  = 1'b0;
    chk_all("col.mv_tick", 0, 1, 1, 2'd3, 1, 0, 8'd3);
    cyc(1);
    chk_all("col.run", 1, 1, 1, 2'd3, 0, 0, 8'd3);

    // 5c. start while running has no effect
    tick();
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    chk_all("col.start", 1, 1, 1, 2'd2, 0, 0, 8'd3);

    // 5b. game_over beats move_done; display values held
    bus.game_over = 1'b1;
    bus.move_done = 1'b1;
    cyc(1);
    bus.game_over = 1'b0;
    bus.move_done = 1'b0;
    chk_all("col.over", 0, 0, 1, 2'd2, 0, 0, 8'd3);
    bus.game_over = 1'b1;
    cyc(1);
    bus.game_over = 1'b0;
    chk_all("idle.over", 0, 0, 1, 2'd2, 0, 0, 8'd3);

    // 6. turn_count wrap, then reset during SWAP
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    chk_all("wrap.start", 1, 1, 0, 2'd3, 0, 0, 8'd0);
    for (int i = 0; i < 256; i++) begin
      move();
      cyc(1);
      if (i == 254) begin
        chk("wrap.cnt255", 32'(bus.turn_count), 32'd255);
        chk("wrap.turn255", 32'(bus.turn), 32'd1);
      end
    end
    chk_all("wrap.done", 1, 1, 0, 2'd3, 0, 0, 8'd0);
    move();
    chk_all("rst.swap", 0, 1, 1, 2'd3, 1, 0, 8'd1);
    rst       = 1'b1;
    bus.start = 1'b1;
    cyc(1);
    chk_all("rst.mid", 0, 0, 0, 2'd0, 0, 0, 8'd0);
    rst       = 1'b0;
    bus.start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
